// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller: tracks ID/EX, EX/MEM, MEM/WB, produces registered
// bypass selects, load-use stall/bubble and freeze hold. Optional counters under HAZ_STATS_EN.
module ex_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifid_ir,
  input  logic        ifid_valid,
  input  logic        freeze,
  output logic        stall,
  output logic        bubble,
  output logic        bypassAfromMEM,
  output logic        bypassAfromALUinWB,
  output logic        bypassAfromLWinWB,
  output logic        bypassBfromMEM,
  output logic        bypassBfromALUinWB,
  output logic        bypassBfromLWinWB,
`ifdef HAZ_STATS_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] fwd_cnt,
`endif
  output logic [31:0] idex_ir_trk
);
  localparam logic [5:0]  LW      = 6'd35;
  localparam logic [5:0]  SW      = 6'd43;
  localparam logic [5:0]  ALUOP   = 6'd0;
  localparam logic [5:0]  CINDC   = 6'd50;
  localparam logic [5:0]  BEQINIT = 6'd4;
  localparam logic [31:0] NOP_IR  = 32'h0000_0000;

  typedef enum logic [0:0] {RUN = 1'b0, LDUSE = 1'b1} state_t;

  function automatic logic f_is_alu(input logic [31:0] ir);
    return (ir[31:26] == ALUOP) || (ir[31:26] == CINDC);
  endfunction

  function automatic logic [4:0] f_dest(input logic [31:0] ir);
    case (ir[31:26])
      ALUOP, CINDC: return ir[15:11];
      LW:           return ir[20:16];
      default:      return 5'd0;
    endcase
  endfunction

  function automatic logic f_has_a(input logic [31:0] ir);
    case (ir[31:26])
      LW, SW, ALUOP, CINDC, BEQINIT: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic f_has_b(input logic [31:0] ir);
    case (ir[31:26])
      SW, ALUOP, CINDC, BEQINIT: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  state_t      r_state;
  logic [31:0] r_idex, r_exmem, r_memwb;
  logic [5:0]  r_byp;

  logic [31:0] w_eff_ir;
  logic [4:0]  w_a, w_b, w_d_idex, w_d_exmem;
  logic        w_a_en, w_b_en, w_idex_lw, w_exmem_lw, w_ld_use;
  logic [5:0]  w_byp;

  assign w_eff_ir   = ifid_valid ? ifid_ir : NOP_IR;
  assign w_a        = w_eff_ir[25:21];
  assign w_b        = w_eff_ir[20:16];
  assign w_a_en     = f_has_a(w_eff_ir);
  assign w_b_en     = f_has_b(w_eff_ir);
  assign w_d_idex   = f_dest(r_idex);
  assign w_d_exmem  = f_dest(r_exmem);
  assign w_idex_lw  = (r_idex[31:26] == LW);
  assign w_exmem_lw = (r_exmem[31:26] == LW);

  // Younger producer (the one moving into EX/MEM) takes priority over the WB-bound one.
  always_comb begin
    w_byp    = 6'b000000;
    w_byp[5] = w_a_en && f_is_alu(r_idex) && (w_d_idex != 5'd0) && (w_d_idex == w_a);
    w_byp[4] = w_a_en && f_is_alu(r_exmem) && (w_d_exmem != 5'd0) && (w_d_exmem == w_a) && !w_byp[5];
    w_byp[3] = w_a_en && w_exmem_lw && (w_d_exmem != 5'd0) && (w_d_exmem == w_a) && !w_byp[5];
    w_byp[2] = w_b_en && f_is_alu(r_idex) && (w_d_idex != 5'd0) && (w_d_idex == w_b);
    w_byp[1] = w_b_en && f_is_alu(r_exmem) && (w_d_exmem != 5'd0) && (w_d_exmem == w_b) && !w_byp[2];
    w_byp[0] = w_b_en && w_exmem_lw && (w_d_exmem != 5'd0) && (w_d_exmem == w_b) && !w_byp[2];
  end

  assign w_ld_use = (r_state == RUN) && w_idex_lw && (w_d_idex != 5'd0) &&
                    ((w_a_en && (w_d_idex == w_a)) || (w_b_en && (w_d_idex == w_b)));

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (rst) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end else if (freeze) begin
      stall  = 1'b1;
      bubble = 1'b0;
    end else if (w_ld_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_idex  <= NOP_IR;
      r_exmem <= NOP_IR;
      r_memwb <= NOP_IR;
      r_byp   <= 6'b000000;
    end else if (!freeze) begin
      r_memwb <= r_exmem;
      r_exmem <= r_idex;
      if (bubble) begin
        r_idex  <= NOP_IR;
        r_byp   <= 6'b000000;
        r_state <= LDUSE;
      end else begin
        r_idex  <= w_eff_ir;
        r_byp   <= w_byp;
        r_state <= RUN;
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cnt, r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_fwd_cnt   <= 16'd0;
    end else begin
      if (bubble && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (!freeze && !bubble && (|w_byp) && (r_fwd_cnt != 16'hFFFF)) r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

  assign idex_ir_trk        = r_idex;
  assign bypassAfromMEM     = r_byp[5];
  assign bypassAfromALUinWB = r_byp[4];
  assign bypassAfromLWinWB  = r_byp[3];
  assign bypassBfromMEM     = r_byp[2];
  assign bypassBfromALUinWB = r_byp[1];
  assign bypassBfromLWinWB  = r_byp[0];
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl; expected post-edge state queued per step and popped after the edge.
module tb_ex_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, ifid_valid, freeze;
  logic [31:0] ifid_ir;
  logic        stall, bubble;
  logic        aM, aW, aL, bM, bW, bL;
  logic [31:0] idex_ir_trk;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic [5:0]  flags;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_hazard_ctrl dut (
    .clk(clk), .rst(rst), .ifid_ir(ifid_ir), .ifid_valid(ifid_valid), .freeze(freeze),
    .stall(stall), .bubble(bubble),
    .bypassAfromMEM(aM), .bypassAfromALUinWB(aW), .bypassAfromLWinWB(aL),
    .bypassBfromMEM(bM), .bypassBfromALUinWB(bW), .bypassBfromLWinWB(bL),
`ifdef HAZ_STATS_EN
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .idex_ir_trk(idex_ir_trk)
  );

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'd0};
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check stall/bubble, queue post-edge expectation, compare after posedge.
  task automatic step(input string tag, input logic [31:0] ir, input logic v, input logic frz,
                      input logic r, input logic es, input logic eb,
                      input logic [31:0] eir, input logic [5:0] ef);
    exp_t e;
    logic [5:0] got;
    @(negedge clk);
    ifid_ir = ir; ifid_valid = v; freeze = frz; rst = r;
    #1;
    chk1({tag, ".stall"}, stall, es);
    chk1({tag, ".bubble"}, bubble, eb);
    e.tag = tag; e.ir = eir; e.flags = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {aM, aW, aL, bM, bW, bL};
    checks++;
    assert (idex_ir_trk === e.ir) else begin
      fails++;
      $error("FAIL %s.idex_ir: got %h expected %h", e.tag, idex_ir_trk, e.ir);
    end
    checks++;
    assert (got === e.flags) else begin
      fails++;
      $error("FAIL %s.bypass: got %b expected %b", e.tag, got, e.flags);
    end
  endtask

  localparam logic [5:0] LW = 6'd35, SW = 6'd43, ALU = 6'd0, CINDC = 6'd50, BEQ = 6'd4;

  initial begin
    logic [31:0] add3, xor4, nand6, lw7, add8, sgt9, add0, srl4, cin12, sw1, beq1, lw0, add1;
    add3  = rtype(ALU, 5'd1, 5'd2, 5'd3, 6'd32);
    xor4  = rtype(ALU, 5'd3, 5'd5, 5'd4, 6'd38);
    nand6 = rtype(ALU, 5'd5, 5'd3, 5'd6, 6'd39);
    lw7   = itype(LW, 5'd1, 5'd7);
    add8  = rtype(ALU, 5'd7, 5'd2, 5'd8, 6'd32);
    sgt9  = rtype(ALU, 5'd3, 5'd3, 5'd9, 6'd43);
    add0  = rtype(ALU, 5'd1, 5'd2, 5'd0, 6'd32);
    srl4  = rtype(ALU, 5'd0, 5'd5, 5'd4, 6'd2);
    cin12 = rtype(CINDC, 5'd1, 5'd2, 5'd12, 6'd0);
    sw1   = itype(SW, 5'd1, 5'd12);
    beq1  = itype(BEQ, 5'd12, 5'd6);
    lw0   = itype(LW, 5'd1, 5'd0);
    add1  = rtype(ALU, 5'd0, 5'd0, 5'd1, 6'd32);

    rst = 1'b1; freeze = 1'b0; ifid_valid = 1'b0; ifid_ir = 32'h0;
    // reset with an lw in IF/ID: nothing may enter and stall stays low
    step("rst0", lw7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b000000);
    step("rst1", add8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b000000);

    step("add3",   add3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add3,  6'b000000);
    step("xor4",   xor4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, xor4,  6'b100000);
    step("add3b",  add3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add3,  6'b000000);
    step("nop",    sgt9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000);
    step("nand6",  nand6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nand6, 6'b000010);

    step("lw7",    lw7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lw7,   6'b000000);
    step("lu_bub", add8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 6'b000000);
    step("lu_use", add8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add8,  6'b001000);

    step("add3c",  add3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add3,  6'b000000);
    step("add3d",  add3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add3,  6'b000000);
    step("sgt9",   sgt9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sgt9,  6'b100100);

    step("lw7f",   lw7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lw7,   6'b000000);
    for (int i = 0; i < 3; i++)
      step("frz",  add8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, lw7,   6'b000000);
    step("f_bub",  add8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 6'b000000);
    step("f_use",  add8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add8,  6'b001000);
    // freeze while a forwarding instruction is resident: flags and IR must hold
    step("frz_h",  add3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, add8,  6'b001000);

    step("add0",   add0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add0,  6'b000000);
    step("srl4",   srl4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, srl4,  6'b000000);
    step("cin12",  cin12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cin12, 6'b000000);
    step("sw",     sw1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sw1,   6'b000100);
    step("beq",    beq1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, beq1,  6'b010000);
    step("lw0",    lw0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lw0,   6'b000000);
    step("use_r0", add1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add1,  6'b000000);

    step("lw7r",   lw7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lw7,   6'b100000);
    step("r_bub",  add8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 6'b000000);
    step("r_rst",  add8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b000000);
    step("r_post", add8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add8,  6'b000000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
